// File: rtl/rr_onehot_arbiter16.sv
// Round-robin owner of a shared 16-way resource: one-hot grant, hold limit with penalty, dead cycle between owners.
// Latency: grant visible 1 cycle after the request is sampled; release/timeout/revoke take effect on the next edge.
// Backpressure: level requests are the handshake; a requester simply waits (holds req high) while not granted.
module rr_onehot_arbiter16 #(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [N_REQ-1:0]           req_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [$clog2(N_REQ)-1:0]   gnt_idx_o,
    output logic                       gnt_valid_o,
    output logic                       timeout_o,
    output logic [N_REQ-1:0]           penalty_o
);

    localparam int IW  = $clog2(N_REQ);
    localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [HCW-1:0]  hold_cnt;
    logic [N_REQ-1:0] penalty;

    logic [N_REQ-1:0] elig;
    logic            found;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   idx;
    logic            owner_req;
    logic            at_limit;
    logic [N_REQ-1:0] penalty_nxt;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] sel);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    assign elig      = req_i & ~penalty;
    assign owner_req = req_i[gnt_idx_o];
    assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    assign penalty_o = penalty;

    // Rotating priority search: first eligible index at or above ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + IW'(i);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // A timed-out owner is parked until it lets go of its request once.
    always_comb begin
        penalty_nxt = penalty & req_i;
        if (state == GRANT && enable_i && owner_req && at_limit) begin
            penalty_nxt = penalty_nxt | onehot(gnt_idx_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            penalty     <= '0;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            penalty   <= penalty_nxt;
            case (state)
                IDLE: begin
                    if (enable_i && found) begin
                        state       <= GRANT;
                        gnt_idx_o   <= winner;
                        gnt_o       <= onehot(winner);
                        gnt_valid_o <= 1'b1;
                        hold_cnt    <= HCW'(1);
                    end
                end
                GRANT: begin
                    // Revoke and request drop take precedence over the hold limit.
                    if (!enable_i || !owner_req || at_limit) begin
                        state       <= IDLE;
                        gnt_o       <= '0;
                        gnt_valid_o <= 1'b0;
                        hold_cnt    <= '0;
                        ptr         <= gnt_idx_o + IW'(1);
                        timeout_o   <= enable_i && owner_req;
                    end else if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter16.sv
// Directed-vector bench for rr_onehot_arbiter16 built with a hold limit of 4.
module tb_rr_onehot_arbiter16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [15:0] req_i;
    logic [15:0] gnt_o;
    logic [3:0]  gnt_idx_o;
    logic        gnt_valid_o;
    logic        timeout_o;
    logic [15:0] penalty_o;

    int vectors     = 0;
    int miscompares = 0;

    rr_onehot_arbiter16 #(
        .N_REQ    (16),
        .MAX_HOLD (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o),
        .penalty_o   (penalty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        req_i = 16'h0000;
        step();
        rst_i = 1'b0;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] idx);
        chk_vec({tag, "_vld"}, 32'(gnt_valid_o), 32'd1);
        chk_vec({tag, "_idx"}, 32'(gnt_idx_o), 32'(idx));
        chk_vec({tag, "_gnt"}, 32'(gnt_o), 32'(16'h0001 << idx));
    endtask

    task automatic chk_idle(input string tag);
        chk_vec({tag, "_vld"}, 32'(gnt_valid_o), 32'd0);
        chk_vec({tag, "_gnt"}, 32'(gnt_o), 32'd0);
    endtask

    logic [3:0] rr_order [5] = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1};

    initial begin
        rst_i    = 1'b1;
        enable_i = 1'b1;
        req_i    = 16'hFFFF;

        // Reset held two cycles with every request up.
        for (int c = 0; c < 2; c++) begin
            step();
            chk_idle("rst");
            chk_vec("rst_pen", 32'(penalty_o), 32'd0);
            chk_vec("rst_to", 32'(timeout_o), 32'd0);
            chk_vec("rst_idx", 32'(gnt_idx_o), 32'd0);
        end
        rst_i = 1'b0;
        step();
        chk_grant("first", 4'd0);
        req_i = 16'h0000;
        step();
        chk_idle("first_rel");

        // Single request, released after three grant cycles; ptr moves to 4.
        reset_dut();
        req_i = 16'h0008;
        step();
        chk_grant("single", 4'd3);
        step();
        step();
        chk_grant("single_hold", 4'd3);
        req_i = 16'h0000;
        step();
        chk_idle("single_rel");
        chk_vec("single_idx_hold", 32'(gnt_idx_o), 32'd3);
        req_i = 16'hFFFF;
        step();
        chk_grant("ptr4", 4'd4);
        req_i = 16'h0000;
        step();

        // Round-robin with wrap: 0,1,15,0,1 with a dead cycle between each.
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            req_i = 16'h8003;
            step();
            chk_grant($sformatf("rr%0d", k), rr_order[k]);
            step();
            chk_grant($sformatf("rr%0d_hold", k), rr_order[k]);
            req_i = 16'h8003 & ~(16'h0001 << rr_order[k]);
            step();
            chk_idle($sformatf("rr%0d_dead", k));
        end

        // Timeout: owner 2 held four cycles, then penalised; 5 granted next.
        reset_dut();
        req_i = 16'h0024;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_grant($sformatf("to_hold%0d", c), 4'd2);
            chk_vec("to_pulse_early", 32'(timeout_o), 32'd0);
        end
        step();
        chk_idle("to_drop");
        chk_vec("to_pulse", 32'(timeout_o), 32'd1);
        chk_vec("to_pen", 32'(penalty_o), 32'h0004);
        step();
        chk_grant("to_next", 4'd5);
        chk_vec("to_pulse_end", 32'(timeout_o), 32'd0);
        chk_vec("to_pen_kept", 32'(penalty_o), 32'h0004);
        req_i = 16'h0004;
        step();
        chk_idle("to_rel5");
        step();
        chk_idle("to_masked");
        chk_vec("to_pen_masked", 32'(penalty_o), 32'h0004);
        req_i = 16'h0000;
        step();
        chk_vec("to_pen_clr", 32'(penalty_o), 32'd0);
        req_i = 16'h0004;
        step();
        chk_grant("to_regrant", 4'd2);
        req_i = 16'h0000;
        step();

        // Enable revoke of owner 7; resume from ptr 8.
        reset_dut();
        req_i = 16'h0080;
        step();
        chk_grant("en_gnt", 4'd7);
        enable_i = 1'b0;
        step();
        chk_idle("en_rev");
        chk_vec("en_to", 32'(timeout_o), 32'd0);
        chk_vec("en_pen", 32'(penalty_o), 32'd0);
        req_i = 16'hFFFF;
        step();
        step();
        chk_idle("en_blocked");
        enable_i = 1'b1;
        step();
        chk_grant("en_resume", 4'd8);
        req_i = 16'h0000;
        step();

        // Request drop on the cycle the limit is reached is a normal release.
        reset_dut();
        req_i = 16'h0002;
        for (int c = 0; c < 4; c++) step();
        chk_grant("lim_at4", 4'd1);
        req_i = 16'h0000;
        step();
        chk_idle("lim_rel");
        chk_vec("lim_to", 32'(timeout_o), 32'd0);
        chk_vec("lim_pen", 32'(penalty_o), 32'd0);

        // Enable low together with the limit is a revoke, not a timeout.
        reset_dut();
        req_i = 16'h0002;
        for (int c = 0; c < 4; c++) step();
        enable_i = 1'b0;
        step();
        chk_idle("lim_en");
        chk_vec("lim_en_to", 32'(timeout_o), 32'd0);
        chk_vec("lim_en_pen", 32'(penalty_o), 32'd0);
        enable_i = 1'b1;

        // Reset in the middle of a grant drops it on that edge.
        req_i = 16'h0000;
        step();
        req_i = 16'h0010;
        step();
        chk_grant("mid_gnt", 4'd2 + 4'd2);
        rst_i = 1'b1;
        step();
        chk_idle("mid_rst");
        chk_vec("mid_rst_idx", 32'(gnt_idx_o), 32'd0);
        rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter16.md
Name: rr_onehot_arbiter16

Overview:
- Sequences the team's 4-to-16 one-hot decode path by sharing a single 16-way resource between 16 requesters.
- Round-robin arbitration produces a registered 4-bit grant index, its decoded one-hot grant vector and a valid flag.
- Safety features: a bounded grant duration, a forced dead cycle between owners, and a one-cycle timeout pulse for the monitoring logic.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16, index width 4.
- MAX_HOLD, 64, maximum consecutive grant cycles per owner; 0 disables the timeout.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- enable_i  input  1  arbiter enable; low blocks new grants and revokes the current grant.
- req_i  input  16  request per requester; level, held high for as long as the resource is wanted.
- gnt_o  output  16  one-hot grant, equal to (1 << gnt_idx_o) when gnt_valid_o=1, else 16'h0000.
- gnt_idx_o  output  4  binary index of the current owner; holds its last value when gnt_valid_o=0.
- gnt_valid_o  output  1  grant active.
- timeout_o  output  1  one-cycle pulse when a grant is revoked because MAX_HOLD was reached.
- penalty_o  output  16  requesters currently masked after a timeout.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE, ptr=0, hold_cnt=0, penalty mask=0.
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0, penalty_o=0.
  - Reset mid-grant drops the grant on that edge.
- States are IDLE and GRANT. All outputs are registered.
- Eligibility: elig = req_i & ~penalty. A penalty bit clears on the first edge at which its req_i bit is sampled low.
- IDLE, arbitration:
  - If enable_i=1 and elig != 0, the winner is the first set bit of elig searching upward from ptr, wrapping 15 -> 0.
  - Next edge: state=GRANT, gnt_idx_o=winner, gnt_o=1<<winner, gnt_valid_o=1, hold_cnt=1.
  - Latency from request sampled to grant visible is 1 cycle.
- GRANT, hold:
  - The grant is kept while req_i[gnt_idx_o]=1, enable_i=1, and (MAX_HOLD=0 or hold_cnt<MAX_HOLD).
  - hold_cnt increments each held cycle and saturates at MAX_HOLD. Width is clog2(MAX_HOLD+1), minimum 1.
- GRANT, normal release:
  - Triggered when req_i[gnt_idx_o]=0 is sampled.
  - Next edge: gnt_valid_o=0, gnt_o=0, state=IDLE, ptr=gnt_idx_o+1 (mod 16).
- GRANT, timeout:
  - Triggered when req_i[gnt_idx_o]=1 and hold_cnt==MAX_HOLD (MAX_HOLD>0).
  - Next edge: grant dropped, state=IDLE, timeout_o=1 for exactly that cycle, penalty[gnt_idx_o]=1, ptr=gnt_idx_o+1.
- GRANT, enable revoke:
  - Triggered when enable_i=0 is sampled.
  - Next edge: grant dropped, state=IDLE, ptr advanced as for a normal release, no timeout, no penalty.
- Dead cycle: every release path passes through at least one IDLE cycle with gnt_valid_o=0. Ownership never changes back-to-back.
- Simultaneous events:
  - Request drop on the same cycle hold_cnt reaches MAX_HOLD is a normal release: no timeout, no penalty.
  - enable_i=0 together with the timeout condition is an enable revoke: no timeout.
- Pointer wrap: a release of index 15 sets ptr=0.
- No eligible requesters: remain in IDLE, outputs hold their reset-style values, ptr unchanged.
- enable_i=0 in IDLE: no grant is issued; penalty bits still clear on request drop.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles with req_i=16'hFFFF -> gnt_valid_o=0, gnt_o=0, penalty_o=0 throughout reset. First grant appears 1 cycle after reset release, with gnt_idx_o=0 and gnt_o=16'h0001.
- Single request: req_i=16'h0008 from cycle 0 -> gnt_o=16'h0008, gnt_idx_o=3 after edge 1. Drop req at cycle 5 -> gnt_valid_o=0 after the next edge, ptr=4.
- Round-robin with wrap: req_i=16'h8003 held, each owner releases after 2 grant cycles -> grant order 0,1,15,0,1, with a dead cycle between each grant.
- Timeout and penalty: MAX_HOLD=4, req_i[2] held with req_i[5] also high -> req 2 held 4 cycles, then timeout_o=1 for 1 cycle and penalty_o=16'h0004. Index 5 is granted next. Req 2 is not granted again until req_i[2] drops for at least 1 cycle.
- Enable revoke: enable_i low during a grant to index 7 -> grant drops next edge, timeout_o=0, penalty_o=0. No new grant while enable_i=0; arbitration resumes from ptr=8 once enable_i returns high.
- Simultaneous release at limit: MAX_HOLD=4, owner drops req on the cycle hold_cnt=4 -> normal release, timeout_o=0, penalty_o unchanged.
